dcache: RTL and testbench

DCACHE -- requirements
Module: dcache

---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_array.sv | 50 +++++
 rtl/dcache.sv | 130 +++++++++++++
 tb/tb_dcache.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int index_width(input int lines);
    return $clog2(lines);
  endfunction

  // Word-addressed lines: two byte-offset bits sit below the index.
  function automatic int tag_width(input int lines);
    return WORD - $clog2(lines) - 2;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache: one combinational read port, one byte-masked write port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 64,
  localparam int IW = index_width(LINES),
  localparam int TW = tag_width(LINES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   rd_index,
  output logic            rd_valid,
  output logic [TW-1:0]   rd_tag,
  output logic [WORD-1:0] rd_data,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_index,
  input  logic [TW-1:0]   wr_tag,
  input  logic [WORD-1:0] wr_data,
  input  logic [3:0]      wr_strb
);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [WORD-1:0]  data_q [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data are left unreset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index] <= wr_tag;
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          data_q[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, one-word-line, write-through/no-write-allocate data cache for the MEM stage.
module dcache
  import dcache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        DCache_ready,
  output logic [31:0] rdata,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_ready,
  input  logic [31:0] mem_rd_data,
  output logic        mem_wr_req,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_strb,
  input  logic        mem_wr_ready
);

  localparam int IW = index_width(LINES);
  localparam int TW = tag_width(LINES);

  state_t          state_q, state_d;
  logic [31:0]     rdata_q;
  logic [IW-1:0]   index;
  logic [TW-1:0]   tag;
  logic            line_valid;
  logic [TW-1:0]   line_tag;
  logic [WORD-1:0] line_data;
  logic            hit;
  logic            arr_we;
  logic [WORD-1:0] arr_wdata;
  logic [3:0]      arr_strb;

  assign index = req_addr[IW+1:2];
  assign tag   = req_addr[31:IW+2];
  assign hit   = line_valid && (line_tag == tag);

  dcache_array #(.LINES(LINES)) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_we),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_data  (arr_wdata),
    .wr_strb  (arr_strb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == REFILL && mem_rd_ready) begin
        rdata_q <= mem_rd_data;
      end
    end
  end

  // The request is held stable until DONE, so memory-side fields come straight from it.
  assign mem_rd_req  = (state_q == REFILL);
  assign mem_rd_addr = {req_addr[31:2], 2'b00};
  assign mem_wr_req  = (state_q == WRITE);
  assign mem_wr_addr = req_addr;
  assign mem_wr_data = req_wdata;
  assign mem_wr_strb = req_wstrb;

  always_comb begin
    state_d      = state_q;
    DCache_ready = 1'b0;
    rdata        = '0;
    arr_we       = 1'b0;
    arr_wdata    = mem_rd_data;
    arr_strb     = 4'hF;
    case (state_q)
      IDLE: begin
        if (!req_valid) begin
          DCache_ready = 1'b1;
        end else if (req_we) begin
          state_d = WRITE;
        end else if (hit) begin
          DCache_ready = 1'b1;
          rdata        = line_data;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (mem_rd_ready) begin
          arr_we  = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        // No write-allocate: only a line already holding this tag is merged.
        if (mem_wr_ready) begin
          arr_we    = hit;
          arr_wdata = req_wdata;
          arr_strb  = req_wstrb;
          state_d   = DONE;
        end
      end
      DONE: begin
        DCache_ready = 1'b1;
        if (req_valid && !req_we) begin
          rdata = rdata_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst) begin
      DCache_ready = 1'b1;
      rdata        = '0;
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed scoreboard bench for dcache: a small memory responder with programmable ready delay.
module tb_dcache;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        DCache_ready;
  logic [31:0] rdata;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_ready;
  logic [31:0] mem_rd_data;
  logic        mem_wr_req;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic        mem_wr_ready;

  int compared;
  int mismatched;
  logic [31:0] exp_q[$];

  dcache #(.LINES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .DCache_ready (DCache_ready),
    .rdata        (rdata),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ready (mem_rd_ready),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_strb  (mem_wr_strb),
    .mem_wr_ready (mem_wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // One access: memory grants ready after 'delay' request cycles; exp_wait is the count of not-ready cycles.
  task automatic applyStimulus(input string name, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb, input int delay,
                               input logic [31:0] mem_data, input logic [31:0] exp_rdata,
                               input int exp_wait);
    int  waits;
    int  rd_seen;
    int  wr_seen;
    bit  done;
    waits   = 0;
    rd_seen = 0;
    wr_seen = 0;
    done    = 1'b0;
    if (!we) exp_q.push_back(exp_rdata);
    @(negedge clk);
    req_valid   = 1'b1;
    req_we      = we;
    req_addr    = addr;
    req_wdata   = wdata;
    req_wstrb   = strb;
    mem_rd_data = mem_data;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_rd_ready = (rd_seen >= delay);
      mem_wr_ready = (wr_seen >= delay);
      #1;
      checkOutput({name, "_excl"}, {31'b0, mem_rd_req & mem_wr_req}, 32'd0);
      if (DCache_ready) begin
        done = 1'b1;
        checkOutput({name, "_wait"}, 32'(waits), 32'(exp_wait));
        if (!we) checkOutput({name, "_rdata"}, rdata, exp_q.pop_front());
        else     checkOutput({name, "_rdata_store"}, rdata, 32'd0);
      end else begin
        waits++;
        checkOutput({name, "_rdata_busy"}, rdata, 32'd0);
        if (mem_rd_req) begin
          rd_seen++;
          checkOutput({name, "_rd_addr"}, mem_rd_addr, {addr[31:2], 2'b00});
        end
        if (mem_wr_req) begin
          wr_seen++;
          checkOutput({name, "_wr_addr"}, mem_wr_addr, addr);
          checkOutput({name, "_wr_data"}, mem_wr_data, wdata);
          checkOutput({name, "_wr_strb"}, {28'b0, mem_wr_strb}, {28'b0, strb});
        end
      end
    end
    if (!done) checkOutput({name, "_timeout_ready"}, {31'b0, DCache_ready}, 32'd1);
    checkOutput({name, "_rd_cycles"}, 32'(rd_seen), (!we && exp_wait > 0) ? 32'(delay + 1) : 32'd0);
    checkOutput({name, "_wr_cycles"}, 32'(wr_seen), we ? 32'(delay + 1) : 32'd0);
    @(negedge clk);
    req_valid    = 1'b0;
    mem_rd_ready = 1'b0;
    mem_wr_ready = 1'b0;
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b0;
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_addr     = 32'h0000_0100;
    req_wdata    = 32'h0;
    req_wstrb    = 4'h0;
    mem_rd_ready = 1'b0;
    mem_rd_data  = 32'h0;
    mem_wr_ready = 1'b0;

    // A pending load during reset must still see ready=1 and rdata=0.
    @(negedge clk);
    #1;
    checkOutput("reset_ready", {31'b0, DCache_ready}, 32'd1);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_rd_req", {31'b0, mem_rd_req}, 32'd0);
    checkOutput("reset_wr_req", {31'b0, mem_wr_req}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checkOutput("idle_ready", {31'b0, DCache_ready}, 32'd1);
      checkOutput("idle_mem_req", {30'b0, mem_rd_req, mem_wr_req}, 32'd0);
    end

    applyStimulus("ld100_miss", 1'b0, 32'h100, 32'h0, 4'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 3);
    applyStimulus("ld100_hit",  1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h0,        32'hDEADBEEF, 0);
    applyStimulus("st100_hit",  1'b1, 32'h100, 32'h11223344, 4'b0011, 0, 32'h0, 32'h0, 2);
    applyStimulus("ld100_merged", 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h0,      32'hDEAD3344, 0);
    applyStimulus("st200_miss", 1'b1, 32'h200, 32'h99887766, 4'hF, 2, 32'h0, 32'h0, 4);
    applyStimulus("ld200_miss", 1'b0, 32'h200, 32'h0, 4'h0, 0, 32'hCAFE0200, 32'hCAFE0200, 2);
    applyStimulus("ld100_evicted", 1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h11110100, 32'h11110100, 3);
    applyStimulus("ld500_conflict", 1'b0, 32'h500, 32'h0, 4'h0, 0, 32'h55550500, 32'h55550500, 2);
    applyStimulus("ld500_hit",  1'b0, 32'h500, 32'h0, 4'h0, 0, 32'h0,        32'h55550500, 0);
    applyStimulus("ld100_remiss", 1'b0, 32'h100, 32'h0, 4'h0, 2, 32'h1111AAAA, 32'h1111AAAA, 4);
    applyStimulus("ld104_miss", 1'b0, 32'h104, 32'h0, 4'h0, 0, 32'h01040104, 32'h01040104, 2);
    applyStimulus("ld100_keep", 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h0,        32'h1111AAAA, 0);

    // Reset in the middle of a refill drops the request and leaves the line invalid.
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = 1'b0;
    req_addr     = 32'h304;
    mem_rd_ready = 1'b0;
    mem_rd_data  = 32'hBAD0BAD0;
    @(negedge clk);
    #1;
    checkOutput("mid_refill_req", {31'b0, mem_rd_req}, 32'd1);
    checkOutput("mid_refill_ready", {31'b0, DCache_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_refill_req", {31'b0, mem_rd_req}, 32'd0);
    checkOutput("rst_refill_ready", {31'b0, DCache_ready}, 32'd1);
    checkOutput("rst_refill_rdata", rdata, 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;

    applyStimulus("ld304_after_rst", 1'b0, 32'h304, 32'h0, 4'h0, 0, 32'h33330304, 32'h33330304, 2);
    applyStimulus("ld100_after_rst", 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h22220100, 32'h22220100, 2);
    applyStimulus("st304_hi",   1'b1, 32'h304, 32'hAABBCCDD, 4'b1100, 1, 32'h0, 32'h0, 3);
    applyStimulus("ld304_merged", 1'b0, 32'h304, 32'h0, 4'h0, 0, 32'h0,      32'hAABB0304, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
